serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_bit.sv | 24 ++
 rtl/serial_addsub.sv | 100 ++++++++++
 tb/tb_serial_addsub.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  // FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operation select values carried on 'sub'
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_bit.sv
// One-bit full-adder / full-subtractor cell, purely combinational.
// Sum and difference share the same XOR. Only the carry and borrow equations differ.
module addsub_bit
  import serial_addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  logic p;
  logic c_add;
  logic c_sub;

  assign p     = x ^ y;
  assign s     = p ^ cin;
  assign c_add = (x & y) | (cin & p);
  assign c_sub = (~x & y) | (cin & ~p);
  assign cout  = (sub == OP_SUB) ? c_sub : c_add;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. It processes one bit per clock, LSB first,
// and uses a start/busy/done handshake.
// On the last RUN edge, the final bit and the final carry/borrow are written
// straight into result/cout. This makes them valid together with the done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             op;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_c;

  addsub_bit u_bit (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .sub  (op),
    .s    (cell_s),
    .cout (cell_c)
  );

  // The new bit enters at the MSB and earlier bits move one place toward the LSB
  assign sum_next = {cell_s, {(WIDTH-1){1'b0}}} | (sum_sr >> 1);

  // FSM, datapath shift registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      op     <= OP_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op    <= sub;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= cell_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            result <= sum_next;
            cout   <= cell_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8). Inputs are driven 1 time unit
// after the rising edge, and outputs are sampled at the same point.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;

  int vectors     = 0;
  int miscompares = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and check latency, busy length, outputs and done width
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic [7:0] er, input logic ec);
    int cyc;
    int bcnt;
    a = ta; b = tb; sub = ts; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 40) begin
      bcnt += int'(busy);
      step();
      cyc++;
    end
    chk({tag, " latency"}, cyc, 9);
    chk({tag, " busy_cycles"}, bcnt, 8);
    chk({tag, " result"}, result, er);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " busy_at_done"}, busy, 0);
    step();
    chk({tag, " done_pulse_width"}, done, 0);
  endtask

  initial begin
    int cyc;
    int bcnt;
    int ndone;
    int last_done;
    int now;
    int w;
    logic [7:0] pa, pb;
    logic       ps;
    logic [8:0] ref9;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    step(); step();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset cout", cout, 0);
    rst = 1'b0;
    step();

    do_op("add 100+27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0);
    do_op("add 200+100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
    do_op("sub 5-3", 8'd5, 8'd3, 1'b1, 8'd2, 1'b0);
    do_op("sub 0-1", 8'd0, 8'd1, 1'b1, 8'd255, 1'b1);
    do_op("sub 170-170", 8'd170, 8'd170, 1'b1, 8'd0, 1'b0);

    // A start pulse in the third RUN cycle must be ignored and must not be queued
    a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    bcnt = int'(busy);
    step(); bcnt += int'(busy);
    step(); bcnt += int'(busy);
    a = 8'd1; b = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 4;
    while (!done && cyc < 40) begin
      bcnt += int'(busy);
      step();
      cyc++;
    end
    chk("ignored_start latency", cyc, 9);
    chk("ignored_start busy_cycles", bcnt, 8);
    chk("ignored_start result", result, 30);
    chk("ignored_start cout", cout, 0);
    ndone = 0;
    repeat (4) begin
      ndone += int'(done);
      step();
    end
    chk("ignored_start done_count", ndone, 1);
    chk("ignored_start no_queued_run", busy, 0);

    // Reset in the fourth RUN cycle aborts the operation and clears the outputs
    a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort cout", cout, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      ndone += int'(done);
      step();
    end
    chk("abort no_done", ndone, 0);
    chk("abort result_held", result, 0);
    do_op("sub 7-9", 8'd7, 8'd9, 1'b1, 8'd254, 1'b1);

    // Start held high: operands are changed right after each acceptance
    a = 8'($urandom_range(255)); b = 8'($urandom_range(255)); sub = 1'($urandom_range(1));
    start = 1'b1;
    now = 0; last_done = 0;
    for (int n = 0; n < 1000; n++) begin
      w = 0;
      while (!busy && w < 20) begin step(); now++; w++; end
      pa = a; pb = b; ps = sub;
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255)); sub = 1'($urandom_range(1));
      w = 0;
      while (!done && w < 20) begin step(); now++; w++; end
      if (ps) ref9 = {1'b0, pa} - {1'b0, pb};
      else    ref9 = {1'b0, pa} + {1'b0, pb};
      chk("stream result", result, ref9[7:0]);
      chk("stream cout", cout, ref9[8]);
      if (n > 0) chk("stream done_interval", now - last_done, 10);
      last_done = now;
    end
    start = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
